reg_dump_sequencer: RTL and testbench

- Debug-unit controller for the register file's debug read port.
- On command, walks every register index 0..CELDAS-1 and drives the debug address.
- Captures each returned word and streams it out byte by byte over a valid/ready byte interface to the UART TX path.
- Used while the CPU is halted to dump the whole register bank to the host.

---
 rtl/reg_dump_sequencer.sv | 135 +++++++++++++
 tb/tb_reg_dump_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: walks the register file's debug read port from index 0
// to CELDAS-1, latches each word and streams it MSB byte first over a
// valid/ready byte interface towards the UART TX path. Used while the CPU is
// halted to dump the whole register bank to the host.
module reg_dump_sequencer #(
    parameter int REGS   = 5,
    parameter int NBITS  = 32,
    parameter int CELDAS = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_halted,
    input  logic             i_abort,
    input  logic [NBITS-1:0] i_reg_data,
    input  logic             i_tx_ready,
    output logic [REGS-1:0]  o_reg_addr,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int NBYTES = NBITS / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [REGS-1:0]  LAST_IDX  = REGS'(CELDAS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [REGS-1:0]  r_index;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [NBITS-1:0] r_shift;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_last_byte;
    logic             w_last_reg;

    // A start is only honoured while halted, and an abort in the same cycle vetoes it.
    assign w_start_ok  = i_start && i_halted && !i_abort;
    assign w_xfer      = (r_state == S_SEND) && i_tx_ready;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_last_reg  = (r_index == LAST_IDX);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; abort overrides every transition outside IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_state_next = S_SEND;
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (w_last_byte) begin
                        w_state_next = w_last_reg ? S_DONE : S_LATCH;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end
    end

    // Index, byte counter and shift register; the index is left untouched by
    // an aborting handshake so the address holds where the dump stopped.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_index    <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_index <= '0;
                    end
                end
                S_LATCH: begin
                    r_shift    <= i_reg_data;
                    r_byte_cnt <= '0;
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        r_shift <= r_shift << 8;
                        if (!w_last_byte) begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end else if (!w_last_reg && !i_abort) begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only; ready never reaches valid combinationally.
    always_comb begin
        o_reg_addr = r_index;
        o_tx_valid = (r_state == S_SEND);
        o_tx_data  = (r_state == S_SEND) ? r_shift[NBITS-1 -: 8] : 8'h00;
        o_busy     = (r_state != S_IDLE);
        o_done     = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Bench for reg_dump_sequencer: a default 32x32 instance driven through full
// dumps, stalls, aborts and an asynchronous reset, plus a 5x16 instance.
module tb_reg_dump_sequencer;

    localparam int CEL = 32;
    localparam int NB  = 32;
    localparam int NBY = NB / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, halted, abort, ready;
    logic [31:0] reg_data;
    logic [4:0]  reg_addr;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;
    logic [31:0] rf [32];

    logic        start2, halted2, abort2, ready2;
    logic [15:0] reg_data2;
    logic [4:0]  reg_addr2;
    logic [7:0]  tx_data2;
    logic        tx_valid2, busy2, done2;
    logic [15:0] rf2 [32];

    int checks = 0;
    int errors = 0;

    assign reg_data  = rf[reg_addr];
    assign reg_data2 = rf2[reg_addr2];

    reg_dump_sequencer #(.REGS(5), .NBITS(32), .CELDAS(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_halted(halted),
        .i_abort(abort), .i_reg_data(reg_data), .i_tx_ready(ready),
        .o_reg_addr(reg_addr), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .o_busy(busy), .o_done(done)
    );

    reg_dump_sequencer #(.REGS(5), .NBITS(16), .CELDAS(5)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_start(start2), .i_halted(halted2),
        .i_abort(abort2), .i_reg_data(reg_data2), .i_tx_ready(ready2),
        .o_reg_addr(reg_addr2), .o_tx_data(tx_data2), .o_tx_valid(tx_valid2),
        .o_busy(busy2), .o_done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready held 1; mode 1: ready toggles 1/0; mode 2: random ready and
    // random register writes during SEND. abort_at >= 0 aborts on that byte.
    task automatic dump_run(input int mode, input int abort_at, output int done_cyc);
        logic [7:0] exp_q[$];
        int         idx_q[$];
        int         cyc, sent, busy_bad, abort_idx;
        logic       stall, r, fin, aborting;
        logic [7:0] prev;
        for (int k = 0; k < CEL; k++)
            for (int b = 0; b < NBY; b++) begin
                exp_q.push_back(rf[k][NB-1-8*b -: 8]);
                idx_q.push_back(k);
            end
        done_cyc = -1; sent = 0; busy_bad = 0; stall = 0; fin = 0;
        aborting = 0; abort_idx = 0; prev = 8'h00; cyc = 0;
        start = 1; halted = 1;
        step();
        start = 0;
        check("latch_addr0", 32'(reg_addr), 0);
        while (cyc < 3000 && !fin) begin
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (stall) begin
                    check("stall_valid", 32'(tx_valid), 1);
                    check("stall_data", 32'(tx_data), 32'(prev));
                end
                if (mode == 0)      r = 1'b1;
                else if (mode == 1) r = (cyc % 2 == 0);
                else                r = 1'($urandom_range(0, 1));
                stall = 0;
                if (tx_valid) begin
                    if (mode == 2) rf[reg_addr] = $urandom;
                    if (r) begin
                        if (exp_q.size() == 0) begin
                            check("extra_byte", 32'(exp_q.size()), 1);
                        end else begin
                            check($sformatf("byte%0d", sent), 32'(tx_data), 32'(exp_q.pop_front()));
                            abort_idx = idx_q.pop_front();
                            check($sformatf("addr%0d", sent), 32'(reg_addr), 32'(abort_idx));
                        end
                        if (sent == abort_at) begin
                            abort = 1;
                            aborting = 1;
                        end
                        sent++;
                    end else begin
                        stall = 1;
                        prev = tx_data;
                    end
                end
                ready = r;
                step();
                abort = 0;
                cyc++;
                if (aborting) begin
                    check("abort_valid", 32'(tx_valid), 0);
                    check("abort_busy", 32'(busy), 0);
                    check("abort_done", 32'(done), 0);
                    check("abort_addr_hold", 32'(reg_addr), 32'(abort_idx));
                    fin = 1;
                    done_cyc = -2;
                end
            end
        end
        ready = 0;
        check("dump_finished", 32'(fin), 1);
        check("busy_throughout", 32'(busy_bad), 0);
        if (done_cyc >= 0) begin
            check("all_bytes_sent", 32'(exp_q.size()), 0);
            check("done_addr", 32'(reg_addr), CEL - 1);
            check("done_valid", 32'(tx_valid), 0);
            step();
            check("done_one_cycle", 32'(done), 0);
            check("idle_after_done", 32'(busy), 0);
        end
    endtask

    initial begin
        int dc, bad, n2, cyc2;
        logic [7:0] q2[$];

        rst = 1; start = 0; halted = 0; abort = 0; ready = 0;
        start2 = 0; halted2 = 0; abort2 = 0; ready2 = 0;
        for (int k = 0; k < 32; k++) begin
            rf[k]  = 32'(k);
            rf2[k] = 16'($urandom);
        end
        #1;
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(reg_addr), 0);
        check("rst_data", 32'(tx_data), 0);
        step(); step();
        rst = 0;
        step();

        // Register k holds k, ready held high: 128 bytes, done 160 edges after acceptance.
        dump_run(0, -1, dc);
        check("done_latency", 32'(dc), 160);

        // Start without halt is dropped.
        bad = 0;
        start = 1; halted = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) bad++;
        end
        start = 0;
        check("nohalt_idle_cycles", 32'(bad), 0);
        step();
        check("nohalt_not_queued", 32'(busy), 0);

        // Start together with abort in IDLE does not start.
        start = 1; halted = 1; abort = 1;
        step();
        start = 0; abort = 0;
        check("start_abort_idle", 32'(busy), 0);

        // DEADBEEF at index 3 with ready toggling.
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        rf[3] = 32'hDEADBEEF;
        dump_run(1, -1, dc);

        // Abort during byte 2 of register 10, then a fresh start from index 0.
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        rf[0] = {8'h00, 24'($urandom)};
        dump_run(0, 10 * NBY + 2, dc);
        check("abort_no_done_flag", 32'(dc), 32'(-2));
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_stays_idle", 32'(bad), 0);
        dump_run(2, -1, dc);

        // Asynchronous reset between edges mid-SEND.
        start = 1; halted = 1; ready = 1;
        step();
        start = 0;
        step(); step(); step();
        check("pre_reset_valid", 32'(tx_valid), 1);
        #2 rst = 1;
        #1;
        check("arst_valid", 32'(tx_valid), 0);
        check("arst_data", 32'(tx_data), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_addr", 32'(reg_addr), 0);
        #2 rst = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) bad++;
        end
        ready = 0;
        check("post_reset_idle", 32'(bad), 0);

        // CELDAS=5, NBITS=16 instance.
        for (int k = 0; k < 5; k++) begin
            q2.push_back(rf2[k][15:8]);
            q2.push_back(rf2[k][7:0]);
        end
        n2 = 0; cyc2 = 0;
        start2 = 1; halted2 = 1; ready2 = 1;
        step();
        start2 = 0;
        while (!done2 && cyc2 < 200) begin
            if (tx_valid2) begin
                if (q2.size() > 0) check($sformatf("small_byte%0d", n2), 32'(tx_data2), 32'(q2.pop_front()));
                n2++;
            end
            step();
            cyc2++;
        end
        check("small_done_latency", 32'(cyc2), 15);
        check("small_byte_count", 32'(n2), 10);
        check("small_last_addr", 32'(reg_addr2), 4);
        check("small_done", 32'(done2), 1);
        step();
        check("small_done_pulse", 32'(done2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
